nl_input_buffer: RTL and testbench
==================================

# nl_input_buffer

Router input-port flit buffer sitting directly downstream of a pipelined inter-router channel. Captures flits arriving from the channel's last register stage, stores them in a DEPTH-entry circular FIFO, presents them to the router's allocation logic through a valid/dequeue handshake, and emits one credit pulse per dequeued flit. The credit pulse travels back upstream over a separate credit channel. Overflow is flagged rather than silently absorbed, because credit-based flow control guarantees it never happens in a correct system.

## Interface
Parameters:
- FLIT_W, 64, flit width in bits (payload including head/tail markers)
- DEPTH, 4, FIFO entries; power of two, 2..32
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- flit_in  in  FLIT_W  flit from channel output register
- flit_valid_in  in  1  flit_in carries a flit this cycle
- flit_out  out  FLIT_W  head-of-queue flit
- flit_valid_out  out  1  FIFO non-empty; flit_out is valid
- deq  in  1  router consumes the head flit this cycle; ignored when flit_valid_out=0
- credit_out  out  1  one-cycle pulse per flit dequeued
- occupancy  out  CNT_W  current entry count, 0..DEPTH
- overflow_err  out  1  sticky; set by a write attempt that the FIFO cannot accept

## Operation
- Storage: DEPTH x FLIT_W register array with write pointer wp and read pointer rp, each log2(DEPTH) bits wide. Pointers wrap modulo DEPTH naturally. Full/empty are derived from occupancy, not from pointer comparison.
- Enqueue condition: flit_valid_in=1 and (occupancy<DEPTH or deq_eff=1).
  - On enqueue: mem[wp]<=flit_in, wp<=wp+1.
- deq_eff = deq & flit_valid_out.
  - On deq_eff: rp<=rp+1.
- Occupancy update:
  - +1 on enqueue only.
  - -1 on deq_eff only.
  - Unchanged when both or neither occur.
- Outputs:
  - flit_out = mem[rp], combinational read.
  - flit_valid_out = (occupancy!=0).
- Full with simultaneous deq_eff and flit_valid_in: both occur, the write is accepted, occupancy stays DEPTH.
- Empty with flit_valid_in: no bypass. The flit is visible the next cycle. A deq in that same cycle is ignored.
- Write rejected (flit_valid_in=1, occupancy==DEPTH, deq_eff=0):
  - The flit is dropped.
  - The FIFO is left unchanged.
  - overflow_err<=1 and remains set until reset.
- credit_out: registered; credit_out<=deq_eff.
- flit_in contents are ignored whenever flit_valid_in=0.

## Timing
- Reset (rst_n=0 at a clk edge): wp=rp=0, occupancy=0, flit_valid_out=0, credit_out=0, overflow_err=0. The memory array is not reset, so flit_out is don't-care while flit_valid_out=0.
- Reset mid-operation discards all stored flits. No credits are emitted for discarded flits; the upstream credit counter is reset by the same rst_n.
- Latency: a flit accepted at edge N has flit_valid_out=1 after edge N.
- Credit: deq_eff in cycle N produces credit_out=1 for exactly the cycle after edge N.
- Throughput: one enqueue plus one dequeue per cycle, sustained, at any occupancy including full.
- Ordering: strict FIFO. Flits are never reordered or duplicated.

## Test plan
- Reset then idle: occupancy=0, flit_valid_out=0, credit_out=0, overflow_err=0 for 10 cycles.
- Fill and drain, DEPTH=4, deq=0:
  - Write 0xA0..0xA3 on consecutive cycles: occupancy reaches 4.
  - Then deq=1 for 4 cycles: flit_out sequence A0,A1,A2,A3, four credit pulses each one cycle after its deq, final occupancy=0.
- Simultaneous at full: with 4 entries, write 0xB0 while deq=1:
  - Occupancy stays 4, A0 is dequeued, B0 appears after A3.
  - Check wrap-around across 3 full fill/drain cycles.
- Overflow: with 4 entries, deq=0, write 0xCC:
  - overflow_err=1 from the next cycle and stays 1.
  - Contents remain A0..A3.
  - 0xCC never appears on flit_out.
- Empty corner: write 0xD0 with deq=1 in the same cycle:
  - No credit.
  - Next cycle: flit_valid_out=1 with 0xD0.
  - deq=1 then gives credit_out=1 one cycle later.
- Reset mid-stream: with 3 entries, assert rst_n=0 for one cycle:
  - All outputs are at their reset values.
  - No credit pulse.
  - A subsequent write of 0xE0 is output first.

Source files
------------

// File: rtl/nl_input_buffer.sv
// Router input flit FIFO: a flit accepted at edge N is visible after edge N (no bypass); one credit pulse follows each dequeue.
// No backpressure: upstream credits prevent overrun, and a write into a full FIFO without a dequeue is dropped and flagged.
module nl_input_buffer #(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_valid_in,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid_out,
    input  logic              deq,
    output logic              credit_out,
    output logic [CNT_W-1:0]  occupancy,
    output logic              overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [FLIT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              credit_q, credit_d;
    logic              ovf_q, ovf_d;
    logic              full;
    logic              deq_eff;
    logic              enq;

    always_comb begin
        full     = (occ_q == CNT_W'(DEPTH));
        deq_eff  = deq & (occ_q != '0);
        // At full, a same-cycle dequeue frees the slot the write lands in.
        enq      = flit_valid_in & (~full | deq_eff);

        mem_d    = mem_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        occ_d    = occ_q;
        credit_d = deq_eff;
        ovf_d    = ovf_q | (flit_valid_in & full & ~deq_eff);

        if (enq) begin
            mem_d[wp_q] = flit_in;
            wp_d        = wp_q + PTR_W'(1);
        end
        if (deq_eff) begin
            rp_d = rp_q + PTR_W'(1);
        end
        case ({enq, deq_eff})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage is deliberately left out of reset; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            occ_q    <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            occ_q    <= occ_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign flit_out       = mem_q[rp_q];
    assign flit_valid_out = (occ_q != '0);
    assign credit_out     = credit_q;
    assign occupancy      = occ_q;
    assign overflow_err   = ovf_q;

endmodule

// File: tb/tb_nl_input_buffer.sv
module tb_nl_input_buffer;

    localparam int FLIT_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic [FLIT_W-1:0] flit_in;
    logic              flit_valid_in;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_valid_out;
    logic              deq;
    logic              credit_out;
    logic [CNT_W-1:0]  occupancy;
    logic              overflow_err;

    nl_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flit_in        (flit_in),
        .flit_valid_in  (flit_valid_in),
        .flit_out       (flit_out),
        .flit_valid_out (flit_valid_out),
        .deq            (deq),
        .credit_out     (credit_out),
        .occupancy      (occupancy),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of flits plus the expected flags.
    logic [FLIT_W-1:0] model_q[$];
    logic              exp_credit;
    logic              exp_ovf;
    int                checks;
    int                errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("occupancy", 64'(occupancy), 64'(model_q.size()));
        check("flit_valid_out", 64'(flit_valid_out), 64'(model_q.size() != 0));
        check("credit_out", 64'(credit_out), 64'(exp_credit));
        check("overflow_err", 64'(overflow_err), 64'(exp_ovf));
        if (model_q.size() != 0) check("flit_out", flit_out, model_q[0]);
    endtask

    // One clock: drive at negedge, advance the model, compare just after posedge.
    task automatic step(input logic rst_i, input logic vin, input logic [FLIT_W-1:0] din, input logic dq);
        logic deq_eff;
        @(negedge clk);
        rst_n         = rst_i;
        flit_valid_in = vin;
        flit_in       = din;
        deq           = dq;
        if (!rst_i) begin
            model_q.delete();
            exp_credit = 1'b0;
            exp_ovf    = 1'b0;
        end else begin
            deq_eff    = dq && (model_q.size() != 0);
            exp_credit = deq_eff;
            if (vin && model_q.size() == DEPTH && !deq_eff) exp_ovf = 1'b1;
            if (deq_eff) void'(model_q.pop_front());
            if (vin && model_q.size() < DEPTH) model_q.push_back(din);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [FLIT_W-1:0] rnd;
        checks = 0;
        errors = 0;
        exp_credit = 1'b0;
        exp_ovf = 1'b0;
        rst_n = 1'b0;
        flit_valid_in = 1'b0;
        flit_in = '0;
        deq = 1'b0;

        // Reset, then idle
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);

        // Fill and drain
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 64'hA0 + 64'(i), 1'b0);
        check("fill_occ", 64'(occupancy), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", flit_out, 64'hA0 + 64'(i));
            step(1'b1, 1'b0, '0, 1'b1);
            check("drain_credit", 64'(credit_out), 64'd1);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        check("drain_credit_end", 64'(credit_out), 64'd0);

        // Simultaneous enqueue/dequeue at full, wrapping pointers
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 64'hA0 + 64'(i), 1'b0);
        step(1'b1, 1'b1, 64'hB0, 1'b1);
        check("full_simul_occ", 64'(occupancy), 64'd4);
        check("full_simul_head", flit_out, 64'hA1);
        for (int i = 1; i < 12; i++) step(1'b1, 1'b1, 64'hB0 + 64'(i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

        // Overflow: rejected write leaves contents intact
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 64'hA0 + 64'(i), 1'b0);
        step(1'b1, 1'b1, 64'hCC, 1'b0);
        check("ovf_set", 64'(overflow_err), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_contents", flit_out, 64'hA0 + 64'(i));
            step(1'b1, 1'b0, '0, 1'b1);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        check("ovf_sticky", 64'(overflow_err), 64'd1);

        // Empty corner: no bypass, deq ignored
        step(1'b1, 1'b1, 64'hD0, 1'b1);
        check("empty_no_credit", 64'(credit_out), 64'd0);
        check("empty_head", flit_out, 64'hD0);
        step(1'b1, 1'b0, '0, 1'b1);
        check("empty_credit", 64'(credit_out), 64'd1);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 64'h70 + 64'(i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        check("rst_credit", 64'(credit_out), 64'd0);
        step(1'b1, 1'b1, 64'hE0, 1'b0);
        check("rst_first", flit_out, 64'hE0);
        step(1'b1, 1'b0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom};
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), rnd,
                 ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
